// File: rtl/sha2_pad_blkr.sv
// SHA-2 message padder / block assembler: packets in, padded big-endian blocks out.
// Optional per-message block counter output blk_idx is enabled by SHA2_BLKR_BLKCNT_EN.
module sha2_pad_blkr #(
    parameter int PKT_W    = 64,
    parameter int BLK_PKTS = 8,
    parameter int LEN_W    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      pkt_valid,
    input  logic                      pkt_last,
    input  logic [PKT_W-1:0]          pkt,
    output logic                      pkt_ready,
    output logic                      blk_valid,
    output logic                      blk_last,
    output logic [PKT_W*BLK_PKTS-1:0] blk,
    input  logic                      blk_ready
`ifdef SHA2_BLKR_BLKCNT_EN
    ,
    output logic [15:0]               blk_idx
`endif
);

    // state | meaning
    // MSG   | accepting message packets into the block
    // PAD   | writing the single 1-bit pad packet
    // ZERO  | zero fill, up to the length slots or to the end of an overflow block
    // LEN   | writing the bit count, MSB packet first, into the final slots
    // OUT   | holding a full block until the consumer takes it; 'after' says where to resume

    localparam int BLK_W    = PKT_W * BLK_PKTS;
    localparam int LEN_PKTS = LEN_W / PKT_W;
    localparam int LEN_BASE = BLK_PKTS - LEN_PKTS;
    localparam int IDX_W    = $clog2(BLK_PKTS);
    localparam logic [PKT_W-1:0] PAD_PKT = {1'b1, {(PKT_W-1){1'b0}}};

    if ((PKT_W != 32 && PKT_W != 64) || (LEN_W % PKT_W != 0) || (BLK_PKTS < LEN_PKTS + 2)) begin : g_bad_cfg
        $error("sha2_pad_blkr: unsupported PKT_W/BLK_PKTS/LEN_W combination");
    end

    typedef enum logic [2:0] {S_MSG, S_PAD, S_ZERO, S_LEN, S_OUT} state_t;
    typedef enum logic [1:0] {A_MSG, A_PAD, A_ZERO, A_DONE} after_t;

    state_t            state;
    after_t            after;
    logic [IDX_W-1:0]  idx;
    logic [LEN_W-1:0]  len;
    logic              slot_we;
    logic [PKT_W-1:0]  slot_d;
    logic              last_slot;

    assign last_slot = (idx == IDX_W'(BLK_PKTS - 1));

    always_comb begin
        slot_we = 1'b0;
        slot_d  = '0;
        case (state)
            S_MSG: begin
                slot_we = pkt_valid;
                slot_d  = pkt;
            end
            S_PAD: begin
                slot_we = 1'b1;
                slot_d  = PAD_PKT;
            end
            S_ZERO: slot_we = 1'b1;
            S_LEN: begin
                slot_we = 1'b1;
                for (int k = 0; k < LEN_PKTS; k++) begin
                    if (idx == IDX_W'(LEN_BASE + k)) slot_d = len[LEN_W-1-k*PKT_W -: PKT_W];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= S_MSG;
            after     <= A_MSG;
            idx       <= '0;
            len       <= '0;
            blk       <= '0;
            pkt_ready <= 1'b1;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
`ifdef SHA2_BLKR_BLKCNT_EN
            blk_idx   <= '0;
`endif
        end else begin
            if (slot_we) begin
                for (int s = 0; s < BLK_PKTS; s++) begin
                    if (idx == IDX_W'(s)) blk[BLK_W-1-s*PKT_W -: PKT_W] <= slot_d;
                end
                idx <= idx + IDX_W'(1);
            end

            case (state)
                S_MSG: begin
                    if (pkt_valid) begin
                        len <= len + LEN_W'(PKT_W);
                        if (last_slot) begin
                            state     <= S_OUT;
                            after     <= pkt_last ? A_PAD : A_MSG;
                            pkt_ready <= 1'b0;
                            blk_valid <= 1'b1;
                        end else if (pkt_last) begin
                            state     <= S_PAD;
                            pkt_ready <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    if (idx < IDX_W'(LEN_BASE)) begin
                        state <= (idx == IDX_W'(LEN_BASE - 1)) ? S_LEN : S_ZERO;
                    end else if (last_slot) begin
                        state     <= S_OUT;
                        after     <= A_ZERO;
                        blk_valid <= 1'b1;
                    end else begin
                        state <= S_ZERO;
                    end
                end
                S_ZERO: begin
                    // last_slot can only be hit here when the pad spilled into the length area
                    if (last_slot) begin
                        state     <= S_OUT;
                        after     <= A_ZERO;
                        blk_valid <= 1'b1;
                    end else if (idx == IDX_W'(LEN_BASE - 1)) begin
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (last_slot) begin
                        state     <= S_OUT;
                        after     <= A_DONE;
                        blk_valid <= 1'b1;
                        blk_last  <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (blk_ready) begin
                        idx       <= '0;
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        case (after)
                            A_MSG: begin
                                state     <= S_MSG;
                                pkt_ready <= 1'b1;
                            end
                            A_PAD:  state <= S_PAD;
                            A_ZERO: state <= S_ZERO;
                            default: begin
                                state     <= S_MSG;
                                len       <= '0;
                                pkt_ready <= 1'b1;
                            end
                        endcase
`ifdef SHA2_BLKR_BLKCNT_EN
                        if (after == A_DONE) blk_idx <= '0;
                        else if (blk_idx != 16'hFFFF) blk_idx <= blk_idx + 16'd1;
`endif
                    end
                end
                default: state <= S_MSG;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_pad_blkr.sv
// Self-checking bench for sha2_pad_blkr: queue-based padding model, vector table, hand sequences.
module tb_sha2_pad_blkr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clr;
    logic         pkt_valid, pkt_last, pkt_ready;
    logic [63:0]  pkt;
    logic         blk_valid, blk_last, blk_ready;
    logic [511:0] blk;

    logic          pkt_valid1, pkt_last1, pkt_ready1;
    logic [63:0]   pkt1;
    logic          blk_valid1, blk_last1, blk_ready1;
    logic [1023:0] blk1;
`ifdef SHA2_BLKR_BLKCNT_EN
    logic [15:0]   blk_idx, blk_idx1;
`endif

    sha2_pad_blkr dut0 (
        .clk(clk), .rst(rst), .clr(clr),
        .pkt_valid(pkt_valid), .pkt_last(pkt_last), .pkt(pkt), .pkt_ready(pkt_ready),
        .blk_valid(blk_valid), .blk_last(blk_last), .blk(blk), .blk_ready(blk_ready)
`ifdef SHA2_BLKR_BLKCNT_EN
        , .blk_idx(blk_idx)
`endif
    );

    sha2_pad_blkr #(.PKT_W(64), .BLK_PKTS(16), .LEN_W(128)) dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .pkt_valid(pkt_valid1), .pkt_last(pkt_last1), .pkt(pkt1), .pkt_ready(pkt_ready1),
        .blk_valid(blk_valid1), .blk_last(blk_last1), .blk(blk1), .blk_ready(blk_ready1)
`ifdef SHA2_BLKR_BLKCNT_EN
        , .blk_idx(blk_idx1)
`endif
    );

    localparam logic [63:0] PAD = 64'h8000_0000_0000_0000;

    int total = 0;
    int bad   = 0;

    logic [63:0]  msg_q[$];
    logic [511:0] exp_blk_q[$];
    bit           exp_last_q[$];
    logic [511:0] got_blk_q[$];
    bit           got_last_q[$];
    int           got_idx_q[$];

    typedef struct {
        int          n;
        int          rdy;
        int          gap;
        int          nblk;
        logic [63:0] lenw;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int cur_idx();
`ifdef SHA2_BLKR_BLKCNT_EN
        return int'(blk_idx);
`else
        return 0;
`endif
    endfunction

    // Reference: message ++ pad ++ zeros ++ 64-bit bit count, cut into 8-packet blocks.
    function automatic void build_exp();
        logic [63:0] w[$];
        int nb;
        w = msg_q;
        w.push_back(PAD);
        while (w.size() % 8 != 7) w.push_back(64'd0);
        w.push_back(64'(msg_q.size()) * 64);
        exp_blk_q.delete();
        exp_last_q.delete();
        nb = w.size() / 8;
        for (int b = 0; b < nb; b++) begin
            logic [511:0] v;
            for (int s = 0; s < 8; s++) v[511-64*s -: 64] = w[8*b+s];
            exp_blk_q.push_back(v);
            exp_last_q.push_back(b == nb - 1);
        end
    endfunction

    task automatic rand_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back({$urandom, $urandom});
    endtask

    task automatic run_msg(input int rdy, input int gap, input string tag);
        int sent = 0;
        int cyc  = 0;
        got_blk_q.delete();
        got_last_q.delete();
        got_idx_q.delete();
        while (got_blk_q.size() < exp_blk_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            blk_ready = ($urandom_range(99) < rdy);
            if (blk_valid && blk_ready) begin
                got_blk_q.push_back(blk);
                got_last_q.push_back(blk_last);
                got_idx_q.push_back(cur_idx());
            end
            if (sent < msg_q.size() && $urandom_range(99) >= gap) begin
                pkt_valid = 1'b1;
                pkt       = msg_q[sent];
                pkt_last  = (sent == msg_q.size() - 1);
                if (pkt_ready) sent++;
            end else begin
                pkt_valid = 1'b0;
                pkt       = {$urandom, $urandom};
                pkt_last  = 1'($urandom);
            end
        end
        @(negedge clk);
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        blk_ready = 1'b0;
        if (cyc >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s timeout got_blocks=%0d need=%0d", tag, got_blk_q.size(), exp_blk_q.size());
        end
        chk($sformatf("%s nblk", tag), got_blk_q.size(), exp_blk_q.size());
        for (int i = 0; i < got_blk_q.size() && i < exp_blk_q.size(); i++) begin
            chk($sformatf("%s blk%0d", tag, i), got_blk_q[i], exp_blk_q[i]);
            chk($sformatf("%s last%0d", tag, i), got_last_q[i], exp_last_q[i]);
`ifdef SHA2_BLKR_BLKCNT_EN
            chk($sformatf("%s idx%0d", tag, i), got_idx_q[i], i);
`endif
        end
        chk($sformatf("%s idle_ready", tag), pkt_ready, 1);
        chk($sformatf("%s idle_valid", tag), blk_valid, 0);
    endtask

    task automatic send_pkts(input logic [63:0] a[$], input bit mark_last);
        foreach (a[i]) begin
            @(negedge clk);
            pkt_valid = 1'b1;
            pkt       = a[i];
            pkt_last  = mark_last && (i == a.size() - 1);
        end
        @(negedge clk);
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!blk_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!blk_valid) begin
            total++;
            bad++;
            $display("FAIL %s wait_valid timeout got=0 exp=1", tag);
        end
    endtask

    initial begin
        logic [63:0]  a, b, c, x, y;
        logic [63:0]  pq[$];
        logic [511:0] snap, lastblk;
        int           k;

        tv[0] = '{1, 100, 0, 1, 64'h40};
        tv[1] = '{3, 100, 0, 1, 64'hC0};
        tv[2] = '{6, 70, 20, 1, 64'h180};
        tv[3] = '{7, 100, 0, 2, 64'h1C0};
        tv[4] = '{8, 100, 0, 2, 64'h200};
        tv[5] = '{14, 50, 30, 2, 64'h380};
        tv[6] = '{15, 60, 10, 3, 64'h3C0};
        tv[7] = '{16, 40, 40, 3, 64'h400};

        rst = 1'b1; clr = 1'b0;
        pkt_valid = 0; pkt_last = 0; pkt = '0; blk_ready = 0;
        pkt_valid1 = 0; pkt_last1 = 0; pkt1 = '0; blk_ready1 = 0;
        repeat (3) @(negedge clk);
        chk("rst pkt_ready", pkt_ready, 1);
        chk("rst blk_valid", blk_valid, 0);
        chk("rst blk_last", blk_last, 0);
        chk("rst blk", blk, 0);
        chk("rst1 pkt_ready", pkt_ready1, 1);
        chk("rst1 blk_valid", blk_valid1, 0);
        rst = 1'b0;

        // Three-packet message: latency and exact block
        a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210; c = 64'h1111_2222_3333_4444;
        @(negedge clk);
        blk_ready = 1'b1;
        pkt_valid = 1'b1; pkt = a; pkt_last = 1'b0;
        @(negedge clk); k = 1; pkt = b;
        @(negedge clk); k = 2; pkt = c; pkt_last = 1'b1;
        @(negedge clk); k = 3; pkt_valid = 1'b0; pkt_last = 1'b0;
        while (!blk_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("t3 latency", k, 8);
        chk("t3 blk", blk, {a, b, c, PAD, 64'd0, 64'd0, 64'd0, 64'hC0});
        chk("t3 last", blk_last, 1);
        @(negedge clk);
        blk_ready = 1'b0;
        chk("t3 consumed", blk_valid, 0);

        // Back-pressure: OUT held 5 cycles, packets offered meanwhile must be ignored
        pq = '{64'hD0, 64'hE0, 64'hF0};
        send_pkts(pq, 1'b1);
        wait_valid("bp");
        snap = blk;
        chk("bp blk", snap, {64'hD0, 64'hE0, 64'hF0, PAD, 64'd0, 64'd0, 64'd0, 64'hC0});
`ifdef SHA2_BLKR_BLKCNT_EN
        chk("bp idx", blk_idx, 0);
`endif
        for (int cy = 1; cy <= 5; cy++) begin
            chk($sformatf("bp valid c%0d", cy), blk_valid, 1);
            chk($sformatf("bp hold c%0d", cy), blk, snap);
            chk($sformatf("bp pkt_ready c%0d", cy), pkt_ready, 0);
            pkt_valid = 1'b1; pkt = 64'hDEAD_BEEF; pkt_last = 1'b1;
            @(negedge clk);
        end
        pkt_valid = 1'b0; pkt_last = 1'b0;
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        chk("bp done valid", blk_valid, 0);
        chk("bp done ready", pkt_ready, 1);

        // Table-driven vectors against the model
        foreach (tv[i]) begin
            rand_msg(tv[i].n);
            build_exp();
            run_msg(tv[i].rdy, tv[i].gap, $sformatf("tv%0d", i));
            chk($sformatf("tv%0d nblk_tab", i), got_blk_q.size(), tv[i].nblk);
            lastblk = (got_blk_q.size() > 0) ? got_blk_q[got_blk_q.size()-1] : '1;
            chk($sformatf("tv%0d lenw", i), lastblk[63:0], tv[i].lenw);
        end

        // Abort after 4 packets, then a one-packet message
        pq = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
        send_pkts(pq, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr pkt_ready", pkt_ready, 1);
        chk("clr blk_valid", blk_valid, 0);
        chk("clr blk", blk, 0);
        x = 64'h5A5A_0000_FFFF_1234;
        msg_q = '{x};
        build_exp();
        run_msg(100, 0, "abort");
        lastblk = (got_blk_q.size() > 0) ? got_blk_q[0] : '1;
        chk("abort blk", lastblk, {x, PAD, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h40});

        // Abort while a full block is waiting in OUT
        rand_msg(8);
        send_pkts(msg_q, 1'b0);
        wait_valid("oabort");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("oabort valid", blk_valid, 0);
        chk("oabort blk", blk, 0);
        rand_msg(2);
        build_exp();
        run_msg(80, 10, "post_oabort");

        // Random messages
        for (int r = 0; r < 6; r++) begin
            rand_msg($urandom_range(1, 24));
            build_exp();
            run_msg($urandom_range(30, 100), $urandom_range(0, 50), $sformatf("rnd%0d", r));
        end

        // SHA-512 geometry, one packet
        y = 64'hC0FF_EE00_1234_5678;
        @(negedge clk);
        pkt_valid1 = 1'b1; pkt1 = y; pkt_last1 = 1'b1;
        @(negedge clk);
        pkt_valid1 = 1'b0; pkt_last1 = 1'b0;
        k = 0;
        while (!blk_valid1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("s512 valid", blk_valid1, 1);
        chk("s512 last", blk_last1, 1);
`ifdef SHA2_BLKR_BLKCNT_EN
        chk("s512 idx", blk_idx1, 0);
`endif
        for (int s = 0; s < 16; s++) begin
            logic [63:0] e;
            e = (s == 0) ? y : (s == 1) ? PAD : (s == 15) ? 64'h40 : 64'd0;
            chk($sformatf("s512 slot%0d", s), blk1[1023-64*s -: 64], e);
        end
        blk_ready1 = 1'b1;
        @(negedge clk);
        blk_ready1 = 1'b0;
        chk("s512 consumed", blk_valid1, 0);
        chk("s512 ready", pkt_ready1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
